// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with NR combinational read ports,
// two write lanes (lane 2 is younger and wins collisions), optional
// same-cycle write->read bypass, optional hardwired-zero R0, and a
// per-register busy scoreboard for issue-stage stalling.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR*ADDR_W-1:0]       rd_addr,
  output logic [NR*DATA_W-1:0]       rd_data,
  output logic [NR-1:0]              rd_busy,
  input  logic                       we1,
  input  logic                       we2,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [ADDR_W-1:0]          wa2,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [DATA_W-1:0]          wd2,
  input  logic                       alloc,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int NUM_REGS = 1 << ADDR_W;

  // Flattened views of the per-register state so read ports can index it.
  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;

  // Effective requests: with a hardwired R0, anything aimed at address 0
  // is discarded here so neither storage nor bypass nor scoreboard sees it.
  logic we1_eff;
  logic we2_eff;
  logic alloc_eff;
  logic r0_zero;

  assign r0_zero   = (ZERO_R0 != 0);
  assign we1_eff   = we1   & ~(r0_zero && (wa1 == '0));
  assign we2_eff   = we2   & ~(r0_zero && (wa2 == '0));
  assign alloc_eff = alloc & ~(r0_zero && (alloc_addr == '0));

  genvar gi;

  // One storage slot plus busy flag per architectural register.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;
      logic              busy_reg;
      logic              hit1;
      logic              hit2;
      logic              hit_alloc;

      assign hit1      = we1_eff   && (wa1        == ADDR_W'(gi));
      assign hit2      = we2_eff   && (wa2        == ADDR_W'(gi));
      assign hit_alloc = alloc_eff && (alloc_addr == ADDR_W'(gi));

      // Commit writes (lane 2 overrides lane 1) and update the busy flag;
      // a new allocation outranks a retiring write to the same register
      // because it names the newer producer.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (hit2) begin
            data_reg <= wd2;
          end else if (hit1) begin
            data_reg <= wd1;
          end
          if (hit_alloc) begin
            busy_reg <= 1'b1;
          end else if (hit1 || hit2) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign data_q[gi] = data_reg;
      assign busy_q[gi] = busy_reg;
    end
  endgenerate

  assign busy_vec = busy_q;

  // Read ports: stored value, optionally overridden by in-flight write data.
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Select read data: younger lane first, then older lane, then storage;
      // forwarding is disabled while reset is asserted since nothing commits.
      always_comb begin
        data = data_q[addr];
        if ((BYPASS != 0) && rst_n) begin
          if (we2_eff && (wa2 == addr)) begin
            data = wd2;
          end else if (we1_eff && (wa1 == addr)) begin
            data = wd1;
          end
        end
        if (r0_zero && (addr == '0)) begin
          data = '0;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      // Busy reflects registered state only; a clearing write this cycle
      // is not forwarded, so the consumer still stalls one more cycle.
      assign rd_busy[gi] = busy_q[addr];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives three regfile_mp variants (bypass, no bypass,
// bypass with hardwired R0) from shared stimulus and checks every output
// against an array-based reference model of the register file rules.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NRP  = 2;
  localparam int NREG = 16;
  localparam int NV   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NRP*AW-1:0]   rd_addr;
  logic                we1, we2, alloc;
  logic [AW-1:0]       wa1, wa2, alloc_addr;
  logic [DW-1:0]       wd1, wd2;

  logic [NRP*DW-1:0]   rdd [NV];
  logic [NRP-1:0]      rdb [NV];
  logic [NREG-1:0]     bv  [NV];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(NRP), .BYPASS(1), .ZERO_R0(0)) dut_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_busy(rdb[0]),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .alloc(alloc), .alloc_addr(alloc_addr), .busy_vec(bv[0]));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(NRP), .BYPASS(0), .ZERO_R0(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_busy(rdb[1]),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .alloc(alloc), .alloc_addr(alloc_addr), .busy_vec(bv[1]));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(NRP), .BYPASS(1), .ZERO_R0(1)) dut_zero (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_busy(rdb[2]),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .alloc(alloc), .alloc_addr(alloc_addr), .busy_vec(bv[2]));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state per variant.
  logic [DW-1:0] m_mem  [NV][NREG];
  bit            m_busy [NV][NREG];
  bit            cfg_byp  [NV] = '{1'b1, 1'b0, 1'b1};
  bit            cfg_zero [NV] = '{1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected combinational read value seen by variant v at address a.
  function automatic logic [DW-1:0] exp_rd(input int v, input logic [AW-1:0] a);
    if (cfg_zero[v] && a == 0) return '0;
    if (cfg_byp[v] && rst_n === 1'b1) begin
      if (we2 && wa2 == a) return wd2;
      if (we1 && wa1 == a) return wd1;
    end
    return m_mem[v][a];
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_commit();
    for (int v = 0; v < NV; v++) begin
      if (!rst_n) begin
        for (int r = 0; r < NREG; r++) begin
          m_mem[v][r]  = '0;
          m_busy[v][r] = 1'b0;
        end
      end else begin
        if (we1 && !(cfg_zero[v] && wa1 == 0)) begin
          m_mem[v][wa1]  = wd1;
          m_busy[v][wa1] = 1'b0;
        end
        if (we2 && !(cfg_zero[v] && wa2 == 0)) begin
          m_mem[v][wa2]  = wd2;
          m_busy[v][wa2] = 1'b0;
        end
        if (alloc && !(cfg_zero[v] && alloc_addr == 0))
          m_busy[v][alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0]   a;
    logic [NREG-1:0] eb;
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < NRP; k++) begin
        a = rd_addr[k*AW +: AW];
        chk($sformatf("%s v%0d rd_data%0d", tag, v, k), rdd[v][k*DW +: DW], exp_rd(v, a));
        chk($sformatf("%s v%0d rd_busy%0d", tag, v, k), {31'b0, rdb[v][k]}, {31'b0, m_busy[v][a]});
      end
      for (int r = 0; r < NREG; r++) eb[r] = m_busy[v][r];
      chk($sformatf("%s v%0d busy_vec", tag, v), {16'b0, bv[v]}, {16'b0, eb});
    end
  endtask

  // Check outputs mid-cycle, then clock and update the model.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; we1 = 1'b0; we2 = 1'b0; alloc = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0; we1 = 0; we2 = 0; alloc = 0;
    wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; alloc_addr = 0; rd_addr = '0;
    @(posedge clk);
    model_commit();
    #1;
    idle();
    step("post_reset");

    // 1: fill every register, then a single reset edge clears everything.
    for (int r = 0; r < NREG; r += 2) begin
      we1 = 1; wa1 = AW'(r);     wd1 = $urandom;
      we2 = 1; wa2 = AW'(r + 1); wd2 = $urandom;
      alloc = 1; alloc_addr = AW'(r);
      set_rd(AW'(r), AW'(r + 1));
      step("fill");
    end
    idle(); rst_n = 1'b0;
    step("reset_pulse");
    idle();
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(AW'(r), AW'(r + 1));
      #2;
      chk("reset_zero_p0", rdd[0][31:0], 32'h0);
      chk("reset_zero_p1", rdd[0][63:32], 32'h0);
      step("reset_sweep");
    end

    // 2: write R3 -> bypass variant sees it now, the other after the edge.
    idle(); we1 = 1; wa1 = 3; wd1 = 32'hCCCC_CCCC; set_rd(3, 3);
    #2;
    chk("wr_bypass", rdd[0][31:0], 32'hCCCC_CCCC);
    chk("wr_nobypass_before", rdd[1][31:0], 32'h0);
    step("write_r3");
    idle();
    #2;
    chk("wr_nobypass_after", rdd[1][31:0], 32'hCCCC_CCCC);
    step("read_r3");

    // 3: collision on R5, lane 2 wins.
    idle(); we1 = 1; we2 = 1; wa1 = 5; wa2 = 5;
    wd1 = 32'h1111_1111; wd2 = 32'h2222_2222; set_rd(5, 4);
    step("collide_r5");
    idle();
    #2;
    chk("collide_result", rdd[1][31:0], 32'h2222_2222);
    step("read_r5");

    // 4: scoreboard on R7.
    idle(); alloc = 1; alloc_addr = 7; set_rd(7, 3);
    step("alloc_r7");
    idle();
    #2;
    chk("alloc_busy", {31'b0, rdb[0][0]}, 32'h1);
    we2 = 1; wa2 = 7; wd2 = 32'h7777_0000;
    step("retire_r7");
    idle();
    #2;
    chk("retire_clear", {16'b0, bv[0]}, 32'h0);
    alloc = 1; alloc_addr = 7; we1 = 1; wa1 = 7; wd1 = 32'hABCD_1234;
    step("alloc_and_write_r7");
    idle();
    #2;
    chk("alloc_wins", {31'b0, rdb[1][0]}, 32'h1);
    chk("alloc_wins_data", rdd[1][31:0], 32'hABCD_1234);
    step("read_r7");

    // 5: hardwired R0 behaviour.
    idle(); we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF; alloc = 1; alloc_addr = 0; set_rd(0, 0);
    #2;
    chk("r0_zero_bypass", rdd[2][31:0], 32'h0);
    step("write_r0");
    idle();
    #2;
    chk("r0_zero_busy", {31'b0, bv[2][0]}, 32'h0);
    chk("r0_normal_busy", {31'b0, bv[0][0]}, 32'h1);
    step("read_r0");

    // 6: reset concurrent with write and alloc drops both.
    idle(); rst_n = 0; we1 = 1; wa1 = 9; wd1 = 32'h9999_9999; alloc = 1; alloc_addr = 9; set_rd(9, 7);
    step("reset_mid_op");
    idle();
    #2;
    chk("reset_mid_data", rdd[0][31:0], 32'h0);
    chk("reset_mid_busy", {16'b0, bv[0]}, 32'h0);
    step("after_reset_mid");

    // Randomized traffic, with addresses steered to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      we1 = $urandom_range(0, 1); we2 = $urandom_range(0, 1); alloc = $urandom_range(0, 1);
      wa1 = AW'($urandom_range(0, NREG - 1));
      wa2 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, NREG - 1));
      alloc_addr = ($urandom_range(0, 3) == 0) ? wa2 : AW'($urandom_range(0, NREG - 1));
      wd1 = $urandom; wd2 = $urandom;
      set_rd(($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom_range(0, NREG - 1)),
             ($urandom_range(0, 2) == 0) ? wa2 : AW'($urandom_range(0, NREG - 1)));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
